// File: rtl/avalon_packet_enforcer_pkg.sv
// avalon_packet_enforcer_pkg: shared FSM/mode types and counter width for the packet enforcer
package avalon_packet_enforcer_pack;
  typedef enum logic [1:0] {IDLE, IN_PKT, INSERT_EOP, DISCARD} avalon_packet_enforcer_sm_t;
  typedef enum logic {DSOP_DROP, DSOP_TRUNCATE} dsop_mode_t;
  localparam int ERR_CNT_WIDTH = 16;
endpackage

// File: rtl/avalon_packet_enforcer_if.sv
// avalon_st_if: Avalon-ST bundle (valid/ready/sop/eop/data/empty); master drives, slave sinks
interface avalon_st_if #(
  parameter int DATA_WIDTH = 64,
  parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8)
);
  logic valid;
  logic ready;
  logic sop;
  logic eop;
  logic [DATA_WIDTH-1:0] data;
  logic [EMPTY_WIDTH-1:0] empty;
  modport master (output valid, sop, eop, data, empty, input ready);
  modport slave (input valid, sop, eop, data, empty, output ready);
endinterface

// File: rtl/avalon_packet_enforcer_sat_err_counter.sv
// sat_err_counter: 16-bit saturating event counter; ports clk, rst, inc, clr (wins over inc), count
module sat_err_counter
  import avalon_packet_enforcer_pack::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic [ERR_CNT_WIDTH-1:0] count
);
  logic [ERR_CNT_WIDTH-1:0] r_count;
  always_ff @(posedge clk) begin
    if (rst || clr) r_count <= '0;
    else if (inc && !(&r_count)) r_count <= r_count + 1'b1;
  end
  assign count = r_count;
endmodule

// File: rtl/avalon_packet_enforcer.sv
// avalon_packet_enforcer: repairs SOP/EOP framing of an untrusted Avalon-ST stream; ports clk, rst, untrusted_msg (in), enforced_msg (out), counters_clear, error pulses and saturating counts
module avalon_packet_enforcer
  import avalon_packet_enforcer_pack::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_PKT_BEATS = 256,
  parameter dsop_mode_t DOUBLE_SOP_MODE = DSOP_DROP
) (
  input  logic clk,
  input  logic rst,
  avalon_st_if.slave untrusted_msg,
  avalon_st_if.master enforced_msg,
  input  logic counters_clear,
  output logic missing_sop_error,
  output logic double_sop_error,
  output logic length_error,
  output logic [ERR_CNT_WIDTH-1:0] missing_sop_cnt,
  output logic [ERR_CNT_WIDTH-1:0] double_sop_cnt,
  output logic [ERR_CNT_WIDTH-1:0] length_err_cnt
);
  localparam int CW = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_PKT_BEATS - 1);
  avalon_packet_enforcer_sm_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_data;
  logic w_v, w_rdy, w_sop, w_eop, w_idle, w_in_pkt, w_ins, w_trunc, w_drop, w_stall, w_out_v;
  assign w_v = untrusted_msg.valid & ~rst;
  assign w_rdy = enforced_msg.ready;
  assign w_sop = untrusted_msg.sop;
  assign w_eop = untrusted_msg.eop;
  assign w_data = untrusted_msg.data;
  // DISCARD treats an SOP beat exactly as IDLE does
  assign w_idle = (r_state == IDLE) | (r_state == DISCARD);
  assign w_in_pkt = r_state == IN_PKT;
  assign w_ins = (r_state == INSERT_EOP) & ~rst;
  assign w_trunc = w_v & w_in_pkt & ~w_sop & ~w_eop & (r_cnt == LAST);
  assign w_drop = w_v & ((~w_sop & w_idle) | (w_sop & w_in_pkt & (DOUBLE_SOP_MODE == DSOP_DROP)));
  // the offending SOP is held upstream while the closing EOP is emitted
  assign w_stall = w_v & w_sop & w_in_pkt & (DOUBLE_SOP_MODE == DSOP_TRUNCATE);
  assign missing_sop_error = w_v & ~w_sop & (r_state == IDLE);
  assign double_sop_error = w_v & w_sop & w_in_pkt;
  assign length_error = w_trunc & w_rdy;
  assign w_out_v = w_ins | (w_v & ~w_drop & ~w_stall);
  assign enforced_msg.valid = w_out_v;
  assign enforced_msg.sop = w_sop & ~w_ins;
  assign enforced_msg.eop = w_ins | w_trunc | w_eop;
  assign enforced_msg.empty = (w_out_v & ~w_ins & ~w_trunc) ? untrusted_msg.empty : '0;
  assign enforced_msg.data = (w_out_v & ~w_ins) ? w_data : '0;
  assign untrusted_msg.ready = ~rst & ~w_ins & ~w_stall & (w_drop | w_rdy);
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    if (w_stall) w_state_nxt = INSERT_EOP;
    else if (w_ins) w_state_nxt = w_rdy ? IDLE : INSERT_EOP;
    else if (w_v & w_idle & w_sop & w_rdy) begin
      w_state_nxt = w_eop ? IDLE : IN_PKT;
      w_cnt_nxt = CW'(1);
    end
    else if (w_v & (r_state == DISCARD) & ~w_sop & w_eop) w_state_nxt = IDLE;
    else if (w_v & w_in_pkt & ~w_sop & w_rdy) begin
      w_state_nxt = w_eop ? IDLE : w_trunc ? DISCARD : IN_PKT;
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  sat_err_counter u_miss_cnt (.clk(clk), .rst(rst), .inc(missing_sop_error), .clr(counters_clear), .count(missing_sop_cnt));
  sat_err_counter u_dsop_cnt (.clk(clk), .rst(rst), .inc(double_sop_error), .clr(counters_clear), .count(double_sop_cnt));
  sat_err_counter u_len_cnt (.clk(clk), .rst(rst), .inc(length_error), .clr(counters_clear), .count(length_err_cnt));
endmodule
